// File: rtl/sail_hex_bits_stream_pkg.sv
// Shared types and helpers for the streaming hex-literal parser.
// Holds the parser state encoding, ASCII constants and the nibble bit-length helper.
package sail_hex_pkg;

    typedef enum logic [2:0] {
        S_P0,
        S_P1,
        S_LZ,
        S_DIG,
        S_DRAIN,
        S_DONE
    } sail_hex_state_t;

    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_X_LC = 8'h78;

    function automatic logic [2:0] hex_fnz_width(input logic [3:0] nib);
        if (nib[3])      return 3'd4;
        else if (nib[2]) return 3'd3;
        else if (nib[1]) return 3'd2;
        else if (nib[0]) return 3'd1;
        else             return 3'd0;
    endfunction

endpackage

// File: rtl/sail_hex_bits_stream_if.sv
// Character-in / result-out handshake bundle for the hex-literal parser.
// Both directions use valid/ready; the parser is the slave side.
interface sail_hex_bits_stream_if #(
    parameter int N = 64
);
    logic         in_valid;
    logic [7:0]   in_char;
    logic         in_last;
    logic         in_ready;
    logic         out_valid;
    logic         out_ok;
    logic [N-1:0] out_bits;
    logic         out_ready;

    modport master (
        output in_valid, in_char, in_last, out_ready,
        input  in_ready, out_valid, out_ok, out_bits
    );

    modport slave (
        input  in_valid, in_char, in_last, out_ready,
        output in_ready, out_valid, out_ok, out_bits
    );
endinterface

// File: rtl/sail_hex_bits_stream_nibble_decode.sv
// Combinational ASCII-to-nibble decoder: accepts 0-9, a-f, A-F.
// No latency, no state, no backpressure.
module sail_hex_nibble_decode (
    input  logic [7:0] i_char,
    output logic       o_is_hex,
    output logic [3:0] o_nib,
    output logic       o_is_zero
);
    always_comb begin
        o_is_hex = 1'b1;
        o_nib    = 4'd0;
        if (i_char >= 8'h30 && i_char <= 8'h39) begin
            o_nib = i_char[3:0];
        end else if ((i_char >= 8'h61 && i_char <= 8'h66) ||
                     (i_char >= 8'h41 && i_char <= 8'h46)) begin
            // 'a'/'A' have low nibble 1, so +9 lands on 10..15
            o_nib = i_char[3:0] + 4'd9;
        end else begin
            o_is_hex = 1'b0;
        end
    end

    assign o_is_zero = o_is_hex && (o_nib == 4'd0);

endmodule

// File: rtl/sail_hex_bits_stream.sv
// Streams a "0x..." literal one char/cycle and returns its N-bit value plus an ok flag.
// Result is valid the cycle after the last char is taken and held (in_ready low) until out_ready.
module sail_hex_bits_stream
    import sail_hex_pkg::*;
#(
    parameter  int N      = 64,
    localparam int WCNT_W = $clog2(N + 2)
) (
    input  logic                  clk,
    input  logic                  rst,
    sail_hex_bits_stream_if.slave bus
);
    localparam int WW = WCNT_W + 4;

    sail_hex_state_t    r_state, w_n_state;
    logic [N-1:0]       r_acc, w_n_acc;
    logic [WCNT_W-1:0]  r_wcnt, w_n_wcnt;
    logic               r_seen, w_n_seen;
    logic               r_ok, w_n_ok;
    logic               r_in_ready;

    logic               w_take;
    logic               w_is_hex;
    logic [3:0]         w_nib;
    logic               w_is_zero;
    logic               w_err;
    logic [WW-1:0]      w_wide;
    logic               w_over;
    logic [WCNT_W-1:0]  w_wsat;

    sail_hex_nibble_decode u_dec (
        .i_char    (bus.in_char),
        .o_is_hex  (w_is_hex),
        .o_nib     (w_nib),
        .o_is_zero (w_is_zero)
    );

    assign w_take = bus.in_valid && r_in_ready;

    // Width is tracked one step wider than wcnt so overflow is seen before saturation
    assign w_wide = (r_state == S_LZ) ? WW'(hex_fnz_width(w_nib))
                                      : WW'(r_wcnt) + WW'(4);
    assign w_over = w_wide > WW'(N);
    assign w_wsat = (w_wide > WW'(N + 1)) ? WCNT_W'(N + 1) : w_wide[WCNT_W-1:0];

    always_comb begin
        w_n_state = r_state;
        w_n_acc   = r_acc;
        w_n_wcnt  = r_wcnt;
        w_n_seen  = r_seen;
        w_n_ok    = r_ok;
        w_err     = 1'b0;

        if (r_state == S_DONE) begin
            if (bus.out_ready) begin
                w_n_state = S_P0;
                w_n_acc   = '0;
                w_n_wcnt  = '0;
                w_n_seen  = 1'b0;
                w_n_ok    = 1'b0;
            end
        end else if (w_take) begin
            case (r_state)
                S_P0: begin
                    if (bus.in_char == CH_0 && !bus.in_last) w_n_state = S_P1;
                    else                                     w_err     = 1'b1;
                end
                S_P1: begin
                    if (bus.in_char == CH_X_LC && !bus.in_last) w_n_state = S_LZ;
                    else                                        w_err     = 1'b1;
                end
                S_LZ: begin
                    if (!w_is_hex) begin
                        w_err = 1'b1;
                    end else if (w_is_zero) begin
                        w_n_seen = 1'b1;
                    end else begin
                        w_n_seen  = 1'b1;
                        w_n_acc   = N'(w_nib);
                        w_n_wcnt  = w_wsat;
                        w_n_state = S_DIG;
                        w_err     = w_over;
                    end
                end
                S_DIG: begin
                    if (!w_is_hex) begin
                        w_err = 1'b1;
                    end else begin
                        w_n_acc  = N'({r_acc, w_nib});
                        w_n_wcnt = w_wsat;
                        w_err    = w_over;
                    end
                end
                S_DRAIN: begin
                    if (bus.in_last) begin
                        w_n_state = S_DONE;
                        w_n_ok    = 1'b0;
                    end
                end
                default: w_n_state = S_P0;
            endcase

            if (w_err) begin
                w_n_state = bus.in_last ? S_DONE : S_DRAIN;
                w_n_ok    = 1'b0;
            end else if (bus.in_last && (r_state == S_LZ || r_state == S_DIG)) begin
                w_n_state = S_DONE;
                w_n_ok    = w_n_seen;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_P0;
            r_acc      <= '0;
            r_wcnt     <= '0;
            r_seen     <= 1'b0;
            r_ok       <= 1'b0;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_n_state;
            r_acc      <= w_n_acc;
            r_wcnt     <= w_n_wcnt;
            r_seen     <= w_n_seen;
            r_ok       <= w_n_ok;
            r_in_ready <= (w_n_state != S_DONE);
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.out_ok    = r_ok;
    assign bus.out_bits  = r_ok ? r_acc : '0;

endmodule

// File: tb/tb_sail_hex_bits_stream.sv
// Directed and table-driven checks of the hex-literal parser at N=8, N=9 and N=64.
module tb_sail_hex_bits_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv   [3];
    logic [7:0]  ic   [3];
    logic        il   [3];
    logic        ordy [3];
    logic        ir   [3];
    logic        ov   [3];
    logic        ook  [3];
    logic [63:0] ob   [3];

    sail_hex_bits_stream_if #(.N(8))  if8  ();
    sail_hex_bits_stream_if #(.N(9))  if9  ();
    sail_hex_bits_stream_if #(.N(64)) if64 ();

    sail_hex_bits_stream #(.N(8))  u8  (.clk(clk), .rst(rst), .bus(if8));
    sail_hex_bits_stream #(.N(9))  u9  (.clk(clk), .rst(rst), .bus(if9));
    sail_hex_bits_stream #(.N(64)) u64 (.clk(clk), .rst(rst), .bus(if64));

    assign if8.in_valid   = iv[0];
    assign if8.in_char    = ic[0];
    assign if8.in_last    = il[0];
    assign if8.out_ready  = ordy[0];
    assign ir[0]          = if8.in_ready;
    assign ov[0]          = if8.out_valid;
    assign ook[0]         = if8.out_ok;
    assign ob[0]          = 64'(if8.out_bits);

    assign if9.in_valid   = iv[1];
    assign if9.in_char    = ic[1];
    assign if9.in_last    = il[1];
    assign if9.out_ready  = ordy[1];
    assign ir[1]          = if9.in_ready;
    assign ov[1]          = if9.out_valid;
    assign ook[1]         = if9.out_ok;
    assign ob[1]          = 64'(if9.out_bits);

    assign if64.in_valid  = iv[2];
    assign if64.in_char   = ic[2];
    assign if64.in_last   = il[2];
    assign if64.out_ready = ordy[2];
    assign ir[2]          = if64.in_ready;
    assign ov[2]          = if64.out_valid;
    assign ook[2]         = if64.out_ok;
    assign ob[2]          = if64.out_bits;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int          dut;
        string       lit;
        logic        exp_ok;
        logic [63:0] exp_bits;
    } vec_t;

    vec_t vt[14];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge
    task automatic send_char(input int d, input logic [7:0] c, input logic last, input string nm);
        int t;
        iv[d] = 1'b1;
        ic[d] = c;
        il[d] = last;
        t = 0;
        while (!ir[d] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check({nm, "/ready_timeout"}, 64'(ir[d]), 64'd1);
        @(negedge clk);
        iv[d] = 1'b0;
        il[d] = 1'b0;
        ic[d] = 8'h3f;
        if (!last) begin
            check({nm, "/no_early_valid"}, 64'(ov[d]), 64'd0);
            check({nm, "/ready_mid"}, 64'(ir[d]), 64'd1);
        end
    endtask

    task automatic run_lit(input int d, input string s, input logic eok, input logic [63:0] ebits,
                           input int gap, input int hold, input string nm);
        for (int i = 0; i < s.len(); i++) begin
            repeat ($urandom_range(0, gap)) @(negedge clk);
            send_char(d, s[i], (i == s.len() - 1), nm);
        end
        check({nm, "/valid"}, 64'(ov[d]), 64'd1);
        check({nm, "/ok"}, 64'(ook[d]), 64'(eok));
        check({nm, "/bits"}, ob[d], ebits);
        check({nm, "/ready_low"}, 64'(ir[d]), 64'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({nm, "/hold_valid"}, 64'(ov[d]), 64'd1);
            check({nm, "/hold_ok"}, 64'(ook[d]), 64'(eok));
            check({nm, "/hold_bits"}, ob[d], ebits);
            check({nm, "/hold_ready"}, 64'(ir[d]), 64'd0);
        end
        ordy[d] = 1'b1;
        @(negedge clk);
        ordy[d] = 1'b0;
        check({nm, "/valid_drop"}, 64'(ov[d]), 64'd0);
        check({nm, "/ready_back"}, 64'(ir[d]), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string       s;
        logic [63:0] v;
        logic [3:0]  nb;
        logic [7:0]  ch;
        int          nd;

        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0; ic[d] = 8'h00; il[d] = 1'b0; ordy[d] = 1'b0;
        end

        vt[0]  = '{0, "0x00FF", 1'b1, 64'hFF};
        vt[1]  = '{0, "0x1FF",  1'b0, 64'h0};
        vt[2]  = '{1, "0x1FF",  1'b1, 64'h1FF};
        vt[3]  = '{0, "0x10",   1'b1, 64'h10};
        vt[4]  = '{0, "0x0",    1'b1, 64'h0};
        vt[5]  = '{0, "0x",     1'b0, 64'h0};
        vt[6]  = '{0, "0X1",    1'b0, 64'h0};
        vt[7]  = '{0, "0xg12",  1'b0, 64'h0};
        vt[8]  = '{0, "0xaB",   1'b1, 64'hAB};
        vt[9]  = '{0, "0x100",  1'b0, 64'h0};
        vt[10] = '{2, "0x0ffffffffffffffff", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
        vt[11] = '{2, "0x10000000000000000", 1'b0, 64'h0};
        vt[12] = '{0, "1x5",    1'b0, 64'h0};
        vt[13] = '{1, "0x000100", 1'b1, 64'h100};

        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("reset/in_ready",  64'(ir[d]),  64'd0);
            check("reset/out_valid", 64'(ov[d]),  64'd0);
            check("reset/out_ok",    64'(ook[d]), 64'd0);
            check("reset/out_bits",  ob[d],       64'd0);
        end
        rst = 1'b0;
        check("release/ready_still_low", 64'(ir[0]), 64'd0);
        @(negedge clk);
        check("release/ready_rises", 64'(ir[0]), 64'd1);

        for (int k = 0; k < 14; k++)
            run_lit(vt[k].dut, vt[k].lit, vt[k].exp_ok, vt[k].exp_bits, 1, 1,
                    $sformatf("vec%0d", k));

        // Stalled input with in_char/in_last toggling must not change state
        iv[0] = 1'b0; ic[0] = 8'h30; il[0] = 1'b1;
        repeat (3) @(negedge clk);
        check("stall/no_valid", 64'(ov[0]), 64'd0);
        run_lit(0, "0x5", 1'b1, 64'h5, 0, 0, "after_stall");

        for (int r = 0; r < 6; r++) begin
            nd = $urandom_range(1, 16);
            v  = {$urandom, $urandom};
            if (nd < 16) v = v & ((64'd1 << (nd * 4)) - 64'd1);
            s = "0x";
            repeat ($urandom_range(0, 2)) s = {s, "0"};
            for (int k = nd - 1; k >= 0; k--) begin
                nb = v[k*4 +: 4];
                if (nb < 4'd10) ch = 8'h30 + 8'(nb);
                else            ch = (($urandom_range(0, 1) == 1) ? 8'h41 : 8'h61) + 8'(nb) - 8'd10;
                s = $sformatf("%s%c", s, ch);
            end
            run_lit(2, s, 1'b1, v, 2, 5, $sformatf("rand%0d", r));
        end

        // Abort mid-literal
        send_char(0, 8'h30, 1'b0, "abort");
        send_char(0, 8'h78, 1'b0, "abort");
        send_char(0, 8'h33, 1'b0, "abort");
        rst = 1'b1;
        #1;
        check("abort/in_ready",  64'(ir[0]),  64'd0);
        check("abort/out_valid", 64'(ov[0]),  64'd0);
        check("abort/out_ok",    64'(ook[0]), 64'd0);
        check("abort/out_bits",  ob[0],       64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_lit(0, "0x7", 1'b1, 64'h7, 0, 1, "post_abort");

        // Reset while the result is being held
        send_char(0, 8'h30, 1'b0, "abort_done");
        send_char(0, 8'h78, 1'b0, "abort_done");
        send_char(0, 8'h39, 1'b1, "abort_done");
        check("abort_done/valid_before", 64'(ov[0]), 64'd1);
        rst = 1'b1;
        #1;
        check("abort_done/out_valid", 64'(ov[0]),  64'd0);
        check("abort_done/out_bits",  ob[0],       64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
